// File: rtl/riscv_isa_pkg.sv
// RV32I constants shared by the encoder and the decode stage so both ends agree
// on opcodes, instruction classes, formats and immediate ranges.
package riscv_isa_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [3:0] {
        CLS_BRANCH = 4'd0,
        CLS_JALR   = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_LUI    = 4'd3,
        CLS_AUIPC  = 4'd4,
        CLS_OP_IMM = 4'd5,
        CLS_OP     = 4'd6,
        CLS_LOAD   = 4'd7,
        CLS_STORE  = 4'd8,
        CLS_FENCE  = 4'd9
    } class_sel_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam int unsigned IMM_W_I = 12;
    localparam int unsigned IMM_W_B = 13;
    localparam int unsigned IMM_W_J = 21;

    // True when imm is representable as a signed value of width w.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned w);
        logic [31:0] upper;
        upper = $signed(imm) >>> (w - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Generic valid/ready FIFO; head data reads as zero while empty.
module instruction_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 33
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (wr_ptr == {~rd_ptr[PTR_W], rd_ptr[PTR_W-1:0]});
    assign pop_valid  = (wr_ptr != rd_ptr);
    assign push_ready = reset_n & ~full;
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_valid & pop_ready;
    assign pop_data   = pop_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // push_ready already carries reset_n, so storage needs no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32I instruction fields into a 32-bit word, flags illegal immediates or
// classes, and buffers the result in a small output FIFO with emit/error counters.
module instruction_encoder
    import riscv_isa_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             class_select,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [31:0]            immediate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            instruction,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] emitted_count,
    output logic [7:0]             error_count
);
    logic [6:0]  opcode;
    fmt_e        fmt;
    logic        class_bad;
    logic        imm_bad;
    logic [31:0] packed_word;
    logic [31:0] enc_word;
    logic        enc_error;
    logic [31:0] imm;

    assign imm = immediate;

    always_comb begin
        opcode    = OPC_OP_IMM;
        fmt       = FMT_I;
        class_bad = 1'b0;
        case (class_sel_e'(class_select))
            CLS_BRANCH: begin opcode = OPC_BRANCH; fmt = FMT_B; end
            CLS_JALR:   begin opcode = OPC_JALR;   fmt = FMT_I; end
            CLS_JAL:    begin opcode = OPC_JAL;    fmt = FMT_J; end
            CLS_LUI:    begin opcode = OPC_LUI;    fmt = FMT_U; end
            CLS_AUIPC:  begin opcode = OPC_AUIPC;  fmt = FMT_U; end
            CLS_OP_IMM: begin opcode = OPC_OP_IMM; fmt = FMT_I; end
            CLS_OP:     begin opcode = OPC_OP;     fmt = FMT_R; end
            CLS_LOAD:   begin opcode = OPC_LOAD;   fmt = FMT_I; end
            CLS_STORE:  begin opcode = OPC_STORE;  fmt = FMT_S; end
            CLS_FENCE:  begin opcode = OPC_FENCE;  fmt = FMT_I; end
            default:    class_bad = 1'b1;
        endcase
    end

    always_comb begin
        imm_bad     = 1'b0;
        packed_word = '0;
        case (fmt)
            FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                packed_word = {imm[11:0], rs1, funct3, rd, opcode};
                imm_bad     = ~imm_fits(imm, IMM_W_I);
            end
            FMT_S: begin
                packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_bad     = ~imm_fits(imm, IMM_W_I);
            end
            FMT_B: begin
                packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_bad     = imm[0] | ~imm_fits(imm, IMM_W_B);
            end
            FMT_U: begin
                packed_word = {imm[31:12], rd, opcode};
                imm_bad     = |imm[11:0];
            end
            FMT_J: begin
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                imm_bad     = imm[0] | ~imm_fits(imm, IMM_W_J);
            end
            default: packed_word = '0;
        endcase
    end

    // An unknown class overrides everything with a NOP so downstream never sees garbage.
    assign enc_word  = class_bad ? NOP_WORD : packed_word;
    assign enc_error = class_bad | imm_bad;

    instruction_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (33)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({enc_error, enc_word}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   ({error, instruction})
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            emitted_count <= '0;
            error_count   <= '0;
        end else if (out_valid && out_ready) begin
            emitted_count <= emitted_count + COUNT_WIDTH'(1);
            if (error && error_count != 8'hFF) error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed expected words.
module tb_instruction_encoder;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  class_select;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        error;
    logic [15:0] emitted_count;
    logic [7:0]  error_count;

    int checks = 0;
    int errors = 0;

    instruction_encoder #(.FIFO_DEPTH(2), .COUNT_WIDTH(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .class_select  (class_select),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct3        (funct3),
        .funct7        (funct7),
        .immediate     (immediate),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instruction   (instruction),
        .error         (error),
        .emitted_count (emitted_count),
        .error_count   (error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [3:0] cls, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
        class_select = cls;
        rd           = d;
        rs1          = s1;
        rs2          = s2;
        funct3       = f3;
        funct7       = f7;
        immediate    = im;
    endtask

    // One accept with out_ready high: word visible the cycle after accept, gone after the pop.
    task automatic encode_one(input string tag, input logic [3:0] cls, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im,
                              input logic [31:0] exp_word, input logic exp_err);
        drive(cls, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_word"}, instruction, exp_word);
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        step();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_emitted", 32'(emitted_count), 32'd0);
        check("rst_errcnt", 32'(error_count), 32'd0);
        reset_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        encode_one("op", 4'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h003100B3, 1'b0);
        check("op_emitted", 32'(emitted_count), 32'd1);
        encode_one("opimm_m1", 4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
        encode_one("opimm_2048", 4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
        check("opimm_errcnt", 32'(error_count), 32'd1);
        encode_one("br_m4", 4'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
        encode_one("br_odd", 4'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, 1'b1);
        encode_one("jal", 4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0);
        encode_one("lui", 4'd3, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        encode_one("lui_bad", 4'd3, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1);
        encode_one("store", 4'd8, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE312C23, 1'b0);
        check("seq_emitted", 32'(emitted_count), 32'd9);
        check("seq_errcnt", 32'(error_count), 32'd3);

        // Backpressure: three bundles offered with the consumer stalled.
        out_ready = 1'b0;
        drive(4'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        step();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        drive(4'd6, 5'd2, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        step();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head_a", instruction, 32'h003100B3);
        drive(4'd6, 5'd3, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_hold_a", instruction, 32'h003100B3);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_head_b", instruction, 32'h00310133);
        check("bp_ready_rise", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_head_c", instruction, 32'h003101B3);
        check("bp_valid_c", 32'(out_valid), 32'd1);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_emitted", 32'(emitted_count), 32'd12);

        // Reset with two words buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(4'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        step();
        step();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        reset_n   = 1'b0;
        check("rst_cycle_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_emitted", 32'(emitted_count), 32'd0);
        check("mid_rst_errcnt", 32'(error_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_in_ready2", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        step();
        check("mid_rst_release", 32'(in_ready), 32'd1);

        encode_one("bad_class", 4'd12, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hDEADBEEF, 32'h00000013, 1'b1);
        check("bad_class_emitted", 32'(emitted_count), 32'd1);
        check("bad_class_errcnt", 32'(error_count), 32'd1);

        // Stream 300 errored words back to back to saturate error_count.
        drive(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("stream_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        step();
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_emitted", 32'(emitted_count), 32'd301);
        check("errcnt_saturate", 32'(error_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
